// File: rtl/spi_pkg.sv
// Shared SPI TX definitions: FSM state encoding and the word width common to the TX FIFO.
package spi_pkg;

  localparam int SPI_WORD_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: one-cycle tick every div_i+1 cycles while running.
// Loading (word start) or firing reloads from div_i, so every phase is timed from its own start.
module spi_half_tick #(
  parameter int DivBits = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_i,
  input  logic               run_i,
  input  logic [DivBits-1:0] div_i,
  output logic               tick_o
);

  localparam logic [DivBits-1:0] CntOne = DivBits'(1);

  logic [DivBits-1:0] cnt_q, cnt_d;

  // Not gated by load_i: the engine decides a burst load on this very tick.
  assign tick_o = run_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || tick_o) begin
      cnt_d = div_i;
    end else if (run_i) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_tx_engine.sv
// SPI mode-0 transmit engine: pops FWFT TX FIFO words and shifts them MSB-first, framed by cs_n.
// Pops only while enable is high; back-to-back words stay in one cs_n burst, 2*WordBits*H cycles each.
module spi_tx_engine
  import spi_pkg::*;
#(
  parameter int WordBits = SPI_WORD_BITS,
  parameter int DivBits  = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [DivBits-1:0]  clk_div,
  input  logic [WordBits-1:0] fifo_rdata,
  input  logic                fifo_empty,
  output logic                fifo_ren,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n,
  output logic                busy,
  output logic                word_done
);

  localparam int CntBits = $clog2(WordBits);
  localparam logic [CntBits-1:0] LastBit = CntBits'(WordBits - 1);
  localparam logic [CntBits-1:0] CntOne  = CntBits'(1);

  spi_state_e          state_q, state_d;
  logic [WordBits-1:0] shreg_q, shreg_d;
  logic [DivBits-1:0]  hdiv_q, hdiv_d;
  logic [CntBits-1:0]  bit_cnt_q, bit_cnt_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                word_done_q, word_done_d;

  logic                load;
  logic                tick;
  logic                word_avail;
  logic [DivBits-1:0]  tick_div;

  assign word_avail = enable && !fifo_empty;
  // A fresh word is timed by the live divider; everything after uses the latched copy.
  assign tick_div   = load ? clk_div : hdiv_q;

  spi_half_tick #(
    .DivBits (DivBits)
  ) u_half_tick (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load),
    .run_i  (state_q != IDLE),
    .div_i  (tick_div),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hdiv_d      = hdiv_q;
    bit_cnt_d   = bit_cnt_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    word_done_d = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = word_avail;
      end
      LEAD: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: advance to the next bit so it is stable at the next rise.
            sclk_d    = 1'b0;
            shreg_d   = {shreg_q[WordBits-2:0], 1'b0};
            mosi_d    = shreg_q[WordBits-2];
            bit_cnt_d = bit_cnt_q + CntOne;
            if (bit_cnt_q == LastBit) begin
              word_done_d = 1'b1;
              if (word_avail) begin
                load = 1'b1;
              end else begin
                state_d = TRAIL;
                mosi_d  = 1'b0;
              end
            end
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d   = LEAD;
      shreg_d   = fifo_rdata;
      hdiv_d    = clk_div;
      bit_cnt_d = '0;
      cs_n_d    = 1'b0;
      sclk_d    = 1'b0;
      mosi_d    = fifo_rdata[WordBits-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hdiv_q      <= '0;
      bit_cnt_q   <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hdiv_q      <= hdiv_d;
      bit_cnt_q   <= bit_cnt_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      word_done_q <= word_done_d;
    end
  end

  assign fifo_ren  = load && rstn;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
  assign busy      = (state_q != IDLE);
  assign word_done = word_done_q;

endmodule
